// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
// At most one request is outstanding: the request is accepted by inst_addr_ok,
// and the read data comes back later with inst_data_ok.
interface inst_fetch_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   modport master (
      output inst_req,
      output inst_addr,
      input  inst_addr_ok,
      input  inst_data_ok,
      input  inst_rdata
   );

   modport slave (
      input  inst_req,
      input  inst_addr,
      output inst_addr_ok,
      output inst_data_ok,
      output inst_rdata
   );
endinterface

// File: rtl/inst_fetch.sv
// Fetch stage: issues one instruction-memory read at a time.
// It holds the fetched instruction until the IF/ID register accepts it.
// A redirect abandons or drains the outstanding read so that no stale data
// reaches ReadDataF.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter logic [31:0] EXC_ADEL = 32'h0000_0004
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        BranchTakenD,
   input  logic [31:0] BranchTargetD,
   input  logic        ExceptionRedirect,
   input  logic [31:0] ExceptionPC,
   inst_fetch_if.master mem,
   output logic [31:0] ReadDataF,
   output logic [31:0] PCF,
   output logic [31:0] PCPlus4F,
   output logic [31:0] PCPlus8F,
   output logic [31:0] ExceptionTypeF,
   output logic        ValidF,
   output logic        FetchStallF
);

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [31:0] pc_r;
   logic [31:0] pc_nxt_s;
   logic [31:0] rdata_r;
   logic [31:0] rdata_nxt_s;
   logic [31:0] exc_r;
   logic [31:0] exc_nxt_s;
   logic        valid_r;
   logic        req_s;

   // Next state, next PC, captured data, and the memory request for this cycle.
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      rdata_nxt_s = rdata_r;
      exc_nxt_s   = exc_r;
      req_s       = 1'b0;
      case (state_r)
         ST_REQ: begin
            if (pc_r[1:0] == 2'b00) begin
               req_s = 1'b1;
               if (ExceptionRedirect) begin
                  // An accepted request must still have its data drained.
                  pc_nxt_s    = ExceptionPC;
                  state_nxt_s = mem.inst_addr_ok ? ST_DRAIN : ST_REQ;
               end else if (mem.inst_addr_ok) begin
                  state_nxt_s = ST_WAIT;
               end else begin
                  state_nxt_s = ST_REQ;
               end
            end else begin
               // A misaligned PC never goes to memory. It completes as an
               // address-error fetch instead.
               if (ExceptionRedirect) begin
                  pc_nxt_s    = ExceptionPC;
                  state_nxt_s = ST_REQ;
               end else begin
                  rdata_nxt_s = 32'h0000_0000;
                  exc_nxt_s   = EXC_ADEL;
                  state_nxt_s = ST_HOLD;
               end
            end
         end
         ST_WAIT: begin
            if (ExceptionRedirect) begin
               pc_nxt_s    = ExceptionPC;
               state_nxt_s = mem.inst_data_ok ? ST_REQ : ST_DRAIN;
            end else if (mem.inst_data_ok) begin
               rdata_nxt_s = mem.inst_rdata;
               exc_nxt_s   = 32'h0000_0000;
               state_nxt_s = ST_HOLD;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_HOLD: begin
            if (ExceptionRedirect) begin
               pc_nxt_s    = ExceptionPC;
               state_nxt_s = ST_REQ;
            end else if (!StallF) begin
               // The instruction being handed off is the delay slot, so the
               // branch decision is taken at this point.
               pc_nxt_s    = BranchTakenD ? BranchTargetD : (pc_r + 32'd4);
               state_nxt_s = ST_REQ;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         ST_DRAIN: begin
            if (ExceptionRedirect) begin
               pc_nxt_s = ExceptionPC;
            end else begin
               pc_nxt_s = pc_r;
            end
            // The drained response closes the old transaction even if a new
            // redirect arrives in the same cycle.
            if (mem.inst_data_ok) begin
               state_nxt_s = ST_REQ;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         default: begin
            state_nxt_s = ST_REQ;
         end
      endcase
   end

   // State and F-stage output registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_REQ;
         pc_r    <= RESET_PC;
         rdata_r <= 32'h0000_0000;
         exc_r   <= 32'h0000_0000;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         pc_r    <= pc_nxt_s;
         rdata_r <= rdata_nxt_s;
         exc_r   <= exc_nxt_s;
         valid_r <= (state_nxt_s == ST_HOLD);
      end
   end

   // The request is suppressed while reset is held. It then appears in the
   // first cycle after reset is released.
   assign mem.inst_req  = req_s & rst;
   assign mem.inst_addr = pc_r;

   assign ReadDataF      = rdata_r;
   assign PCF            = pc_r;
   assign PCPlus4F       = pc_r + 32'd4;
   assign PCPlus8F       = pc_r + 32'd8;
   assign ExceptionTypeF = exc_r;
   assign ValidF         = valid_r;
   assign FetchStallF    = ~valid_r;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC SHALL exist: default 32'hBFC0_0000; the PC loaded on reset.
REQ-002 Parameter EXC_ADEL SHALL exist: default 32'h0000_0004; the ExceptionTypeF value for a misaligned fetch.
REQ-003 Port clk SHALL be: input, 1 bit; single clock, rising edge.
REQ-004 Port rst SHALL be: input, 1 bit; asynchronous, active-low reset.
REQ-005 Port StallF SHALL be: input, 1 bit; downstream IF/ID register cannot accept this cycle.
REQ-006 Port BranchTakenD SHALL be: input, 1 bit; decode resolved a taken branch or jump. Held stable until the fetch handoff.
REQ-007 Port BranchTargetD SHALL be: input, 32 bits; branch/jump target.
REQ-008 Port ExceptionRedirect SHALL be: input, 1 bit; one-cycle pulse; redirect fetch to ExceptionPC.
REQ-009 Port ExceptionPC SHALL be: input, 32 bits; exception handler or ERET target.
REQ-010 Port inst_req SHALL be: output, 1 bit; instruction memory request.
REQ-011 Port inst_addr SHALL be: output, 32 bits; request address.
REQ-012 Port inst_addr_ok SHALL be: input, 1 bit; memory accepted the request this cycle.
REQ-013 Port inst_data_ok SHALL be: input, 1 bit; read data valid this cycle.
REQ-014 Port inst_rdata SHALL be: input, 32 bits; read data.
REQ-015 Port ReadDataF SHALL be: output, 32 bits; fetched instruction.
REQ-016 Port PCF SHALL be: output, 32 bits; PC of the fetched instruction.
REQ-017 Ports PCPlus4F and PCPlus8F SHALL be: outputs, 32 bits each; PCF+4 and PCF+8.
REQ-018 Port ExceptionTypeF SHALL be: output, 32 bits; fetch exception code.
REQ-019 Port ValidF SHALL be: output, 1 bit; the F-stage outputs hold a completed fetch.
REQ-020 Port FetchStallF SHALL be: output, 1 bit; fetch not complete, so the pipeline must stall.

Function
REQ-021 The FSM SHALL have the states REQ, WAIT, HOLD and DRAIN; at most one memory transaction outstanding.
REQ-022 In REQ with PCF[1:0]==0: inst_req=1, inst_addr=PCF; on inst_addr_ok go to WAIT.
REQ-023 In REQ with PCF[1:0]!=0: no request; next cycle go to HOLD with ReadDataF=0 and ExceptionTypeF=EXC_ADEL.
REQ-024 In WAIT: inst_req=0; on inst_data_ok capture inst_rdata into ReadDataF, set ExceptionTypeF=0, go to HOLD.
REQ-025 ValidF SHALL be 1 exactly in HOLD; FetchStallF SHALL equal !ValidF; outputs stay stable throughout HOLD.
REQ-026 Handoff SHALL occur in HOLD with StallF==0; next cycle the state is REQ and PCF is the next PC.
REQ-027 Next PC priority SHALL be: ExceptionRedirect ? ExceptionPC : BranchTakenD ? BranchTargetD : PCF+4. BranchTakenD is sampled only at handoff, because the delay-slot instruction is the one being handed off.
REQ-028 ExceptionRedirect in REQ without inst_addr_ok SHALL give: PCF<=ExceptionPC, stay in REQ. The request may be withdrawn because no handshake occurred.
REQ-029 ExceptionRedirect in REQ with inst_addr_ok, or in WAIT without inst_data_ok, SHALL give: PCF<=ExceptionPC, go to DRAIN.
REQ-030 ExceptionRedirect in WAIT with inst_data_ok in the same cycle SHALL give: discard the data, PCF<=ExceptionPC, go to REQ.
REQ-031 ExceptionRedirect in HOLD SHALL give: PCF<=ExceptionPC, go to REQ, ValidF drops regardless of StallF.
REQ-032 In DRAIN: inst_req=0; on inst_data_ok discard the data and go to REQ. A further ExceptionRedirect updates PCF and stays in DRAIN.
REQ-033 inst_rdata SHALL never reach ReadDataF except on inst_data_ok in WAIT.
REQ-034 PCPlus4F and PCPlus8F SHALL be combinational from PCF, modulo 2^32 (wrap 32'hFFFF_FFFC+4 = 0).

Reset
REQ-035 When rst is low, the block SHALL immediately set: state=REQ, PCF=RESET_PC, ReadDataF=0, ExceptionTypeF=0, ValidF=0, inst_req=0 during reset.
REQ-036 inst_req SHALL assert in the first cycle after rst deasserts.
REQ-037 A transaction in flight when reset asserts SHALL be abandoned; the memory is reset with it.

Verification
REQ-038 Scenario: reset release, addr_ok at cycle 1, data_ok=32'h2402_0001 at cycle 3, StallF=0 -> inst_addr=BFC0_0000; HOLD at cycle 4 with PCF=BFC0_0000, PCPlus8F=BFC0_0008; next request at BFC0_0004.
REQ-039 Scenario: HOLD with StallF=1 for 3 cycles -> outputs frozen, no new inst_req; handoff in the cycle StallF=0.
REQ-040 Scenario: BranchTakenD=1, BranchTargetD=8000_0100 at handoff of the delay slot BFC0_0004 -> next inst_addr=8000_0100.
REQ-041 Scenario: ExceptionRedirect (ExceptionPC=BFC0_0380) in WAIT -> DRAIN; data_ok data dropped (ValidF stays 0); next inst_addr=BFC0_0380.
REQ-042 Scenario: redirect to 8000_0102 -> no inst_req; HOLD with ExceptionTypeF=32'h4, ReadDataF=0.
REQ-043 Scenario: rst pulsed low during WAIT -> outputs at reset values immediately; fetch restarts at RESET_PC.
